priority_arbiter: RTL and testbench
===================================

Name: priority_arbiter

Overview:
- Parametrised, registered successor to the lab's 9-input fixed-priority one-hot encoder.
- Arbitrates N request lines and produces:
  - a one-hot grant,
  - a binary grant index,
  - a valid flag.
- Two run-time modes:
  - Fixed priority: highest index wins, as the combinational encoder did.
  - Round-robin: a rotating priority pointer gives every requester a fair turn.
- Sits between request sources (switches/buttons or peer blocks) and a shared resource or display mux.
- Adds grant hold (lock) and a clock-enable advance strobe.

Parameters:
- N, 9, number of request lines (N >= 2).
- IDXW, 4, width of the binary index; must satisfy 2**IDXW >= N.

Ports:
- clk, input, 1, system clock, rising-edge.
- reset, input, 1, synchronous active-high reset.
- req, input, N, request vector; bit i = requester i.
- en, input, 1, arbitration advance strobe; outputs and state update only when en=1.
- mode, input, 1, 0 = fixed priority (MSB highest), 1 = round-robin.
- hold, input, 1, 1 = keep the current grant while its requester stays asserted.
- grant, output, N, registered one-hot grant (all-zero when idle).
- grant_idx, output, IDXW, binary index of the granted line; 0 when idle.
- grant_valid, output, 1, 1 when grant is non-zero.

Behaviour:
- Clock, reset and latency:
  - Single clock; all state updates on the rising edge of clk.
  - Grant is registered: req sampled at edge t appears on the outputs after edge t (1-cycle latency).
  - There is no combinational req-to-grant path.
- Reset (synchronous, reset=1 at an edge):
  - grant=0, grant_idx=0, grant_valid=0, ptr=N-1.
  - Reset has priority over en, hold and req.
  - Reset mid-grant drops the grant on that edge.
- en=0: grant, grant_idx, grant_valid and ptr all hold their values, regardless of req, mode or hold.
- en=1, with priority in this order:
  1. Hold. If hold=1 and grant_valid=1 and req[grant_idx]=1, outputs and ptr are unchanged.
  2. Idle. Else if req==0: grant=0, grant_idx=0, grant_valid=0; ptr unchanged.
  3. Fixed mode (mode=0). Winner k = highest set index of req.
     - grant=one-hot(k), grant_idx=k, grant_valid=1.
     - ptr unchanged.
  4. Round-robin mode (mode=1). Search order is ptr, ptr-1, …, 0, N-1, …, ptr+1; the first set bit wins (k).
     - grant=one-hot(k), grant_idx=k, grant_valid=1.
     - ptr <= (k==0) ? N-1 : k-1, so the winner becomes lowest priority next time.
- Hold release: if the held requester drops its req (req[grant_idx]=0), normal arbitration applies on the same en edge.
  - In round-robin mode this uses the current ptr, which already excludes the held winner.
- Mode switching:
  - Takes effect at the next en edge.
  - ptr is retained across fixed-mode periods.
  - With ptr=N-1, round-robin reduces to fixed priority for the first grant.
- Invariants:
  - grant is always zero or one-hot.
  - grant_valid == |grant.
  - grant_idx matches the set grant bit.
  - grant_idx < N always.
  - ptr < N always.
- Wrap-around:
  - ptr decrements from 0 to N-1.
  - Indices >= N never occur, including non-power-of-two N.
- Single requester: granted every en cycle in either mode.
  - In round-robin mode, ptr still rotates per the rule above.

Test Plan:
1. Reset and idle (N=9):
   - Stimulus: assert reset with req=9'h1FF for 2 cycles, release, then apply en=1, req=0.
   - Response: grant=0, grant_idx=0 and grant_valid=0 throughout reset and afterwards.
2. Fixed priority:
   - Stimulus: mode=0, en=1, apply req=9'b000101100 for one edge, then req=9'b100000001 for the next edge.
   - Response:
     - After edge 1: grant=9'b000100000, grant_idx=5, valid=1.
     - After edge 2: grant=9'b100000000, grant_idx=8.
3. Round-robin fairness:
   - Stimulus: mode=1, en=1, req=9'b100010010 held constant.
   - Response: grant_idx sequence 8, 4, 1, 8, 4, 1 on consecutive edges.
   - Response: ptr after each grant is 7, 3, 0, 7, …
4. Wrap-around:
   - Stimulus: mode=1, after reset, req=9'b000000001 for one edge, then req=9'b100000011.
   - Response: first grant_idx=0 with ptr→8; next grant_idx=8, then 1, then 0.
5. Hold and release:
   - Stimulus: mode=1, hold=1, req=9'b000011000; after the first grant (idx 4), hold for 4 edges; then clear req[4].
   - Response: grant_idx=4 for all held edges, ptr=3; on the edge after clearing req[4], grant_idx=3.
6. en gating and reset mid-operation:
   - Stimulus: mid-sequence of scenario 3, drop en for 3 edges while changing req; then assert reset for one edge while en=1.
   - Response: outputs frozen during en=0; reset clears grant to 0 and returns ptr to 8.
   - Response: the next grant with req=9'b100010010 is idx 8.

Source files
------------

// File: rtl/priority_arbiter_if.sv
// priority_arbiter_if: request/grant bundle; slave = arbiter (req,en,mode,hold in; grant,grant_idx,grant_valid out), master = requester side
interface priority_arbiter_if #(
  parameter int N    = 9,
  parameter int IDXW = 4
);
  logic [N-1:0]    req;
  logic            en;
  logic            mode;
  logic            hold;
  logic [N-1:0]    grant;
  logic [IDXW-1:0] grant_idx;
  logic            grant_valid;
  modport slave  (input  req, en, mode, hold, output grant, grant_idx, grant_valid);
  modport master (output req, en, mode, hold, input  grant, grant_idx, grant_valid);
endinterface

// File: rtl/priority_arbiter.sv
// priority_arbiter: registered N-way fixed-priority/round-robin arbiter with hold and enable; ports clk, reset (sync, active-high), bus (priority_arbiter_if.slave)
module priority_arbiter #(
  parameter int N    = 9,
  parameter int IDXW = 4
) (
  input logic               clk,
  input logic               reset,
  priority_arbiter_if.slave bus
);
  logic [N-1:0]    r_grant;
  logic [IDXW-1:0] r_idx;
  logic            r_valid;
  logic [IDXW-1:0] r_ptr;
  logic [IDXW-1:0] w_fix;
  logic [IDXW-1:0] w_rr;
  logic [IDXW-1:0] w_k;
  logic [IDXW-1:0] w_ptr_nxt;
  logic            w_hold;
  always_comb begin
    w_fix = '0;
    for (int i = 0; i < N; i++)
      if (bus.req[i]) w_fix = IDXW'(i);
    w_rr = '0;
    for (int d = N - 1; d >= 0; d--)
      if (bus.req[(int'(r_ptr) + N - d) % N]) w_rr = IDXW'((int'(r_ptr) + N - d) % N);
    w_k       = bus.mode ? w_rr : w_fix;
    w_ptr_nxt = (w_k == '0) ? IDXW'(N - 1) : w_k - 1'b1;
    w_hold    = bus.hold && r_valid && bus.req[r_idx];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_grant <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_ptr   <= IDXW'(N - 1);
    end else if (bus.en && !w_hold) begin
      if (bus.req == '0) begin
        r_grant <= '0;
        r_idx   <= '0;
        r_valid <= 1'b0;
      end else begin
        r_grant <= {{(N-1){1'b0}}, 1'b1} << w_k;
        r_idx   <= w_k;
        r_valid <= 1'b1;
        if (bus.mode) r_ptr <= w_ptr_nxt;
      end
    end
  end
  assign bus.grant       = r_grant;
  assign bus.grant_idx   = r_idx;
  assign bus.grant_valid = r_valid;
endmodule

// File: tb/tb_priority_arbiter.sv
// tb_priority_arbiter: directed-vector self-checking bench for priority_arbiter (N=9)
module tb_priority_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  priority_arbiter_if #(.N(9), .IDXW(4)) bus ();
  priority_arbiter #(.N(9), .IDXW(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic expect_out(input string tag, input logic [8:0] g, input int idx, input int ptr);
    check({tag, ".grant"}, 32'(bus.grant), 32'(g));
    check({tag, ".idx"}, 32'(bus.grant_idx), 32'(idx));
    check({tag, ".valid"}, 32'(bus.grant_valid), 32'(g != 0));
    check({tag, ".ptr"}, 32'(dut.r_ptr), 32'(ptr));
  endtask
  task automatic do_reset;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask
  initial begin
    bus.req = 9'h1FF; bus.en = 1'b1; bus.mode = 1'b0; bus.hold = 1'b0;
    // 1: reset and idle
    tick(); expect_out("rst0", 9'h000, 0, 8);
    tick(); expect_out("rst1", 9'h000, 0, 8);
    reset = 1'b0; bus.req = 9'h000;
    tick(); expect_out("idle", 9'h000, 0, 8);
    // 2: fixed priority
    bus.req = 9'b000101100; tick(); expect_out("fix0", 9'b000100000, 5, 8);
    bus.req = 9'b100000001; tick(); expect_out("fix1", 9'b100000000, 8, 8);
    // 3: round-robin fairness
    bus.mode = 1'b1; bus.req = 9'b100010010;
    tick(); expect_out("rr0", 9'b100000000, 8, 7);
    tick(); expect_out("rr1", 9'b000010000, 4, 3);
    tick(); expect_out("rr2", 9'b000000010, 1, 0);
    tick(); expect_out("rr3", 9'b100000000, 8, 7);
    tick(); expect_out("rr4", 9'b000010000, 4, 3);
    tick(); expect_out("rr5", 9'b000000010, 1, 0);
    // 6: en gating then reset mid-operation
    bus.en = 1'b0;
    bus.req = 9'h1FF; tick(); expect_out("frz0", 9'b000000010, 1, 0);
    bus.req = 9'h000; tick(); expect_out("frz1", 9'b000000010, 1, 0);
    bus.req = 9'h003; bus.mode = 1'b0; tick(); expect_out("frz2", 9'b000000010, 1, 0);
    bus.en = 1'b1; bus.mode = 1'b1; bus.req = 9'b100010010; reset = 1'b1;
    tick(); expect_out("midrst", 9'h000, 0, 8);
    reset = 1'b0;
    tick(); expect_out("postrst", 9'b100000000, 8, 7);
    // 4: wrap-around
    do_reset();
    bus.req = 9'b000000001; tick(); expect_out("wrap0", 9'b000000001, 0, 8);
    bus.req = 9'b100000011;
    tick(); expect_out("wrap1", 9'b100000000, 8, 7);
    tick(); expect_out("wrap2", 9'b000000010, 1, 0);
    tick(); expect_out("wrap3", 9'b000000001, 0, 8);
    // 5: hold and release
    do_reset();
    bus.hold = 1'b1; bus.req = 9'b000011000;
    tick(); expect_out("hold0", 9'b000010000, 4, 3);
    for (int i = 0; i < 4; i++) begin
      tick(); expect_out($sformatf("hold%0d", i + 1), 9'b000010000, 4, 3);
    end
    bus.req = 9'b000001000;
    tick(); expect_out("release", 9'b000001000, 3, 2);
    // fixed mode keeps ptr, hold ignored once requester drops
    bus.mode = 1'b0; bus.hold = 1'b0; bus.req = 9'b011000000;
    tick(); expect_out("fixptr", 9'b010000000, 7, 2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
